// File: rtl/jtopl_reg_wr_if.sv
// CPU write bus and operator-ring control bundle for the register write front-end.
// The master side is the CPU/ring controller; the slave side is jtopl_reg_wr.
interface jtopl_reg_wr_if;
    logic       cen;
    logic       addr;
    logic [7:0] din;
    logic       cs_n;
    logic       wr_n;
    logic       busy;
    logic [4:0] slot;
    logic [7:0] din_op;
    logic       up_mult;
    logic       up_ksl_tl;
    logic       up_ar_dr;
    logic       up_sl_rr;
    logic       up_wav;
    logic       update_op_I;
    logic       update_op_II;
    logic       update_op_IV;

    modport master (
        output cen, addr, din, cs_n, wr_n,
        input  busy, slot, din_op,
        input  up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        input  update_op_I, update_op_II, update_op_IV
    );

    modport slave (
        input  cen, addr, din, cs_n, wr_n,
        output busy, slot, din_op,
        output up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        output update_op_I, update_op_II, update_op_IV
    );
endinterface

// File: rtl/jtopl_reg_wr.sv
// Operator register write front-end: latches OPL address/data writes, decodes
// operator registers into a field select and target operator, and holds the
// write for one ring revolution, qualifying the target slot at each field tap.
module jtopl_reg_wr #(
    parameter int LEN    = 18,
    parameter int OFS_II = 1,
    parameter int OFS_IV = 3,
    parameter int OPL2   = 1
) (
    input  logic clk,
    input  logic rst,
    jtopl_reg_wr_if.slave bus
);

    typedef enum logic { ST_IDLE = 1'b0, ST_HOLD = 1'b1 } state_t;

    state_t     state_reg, state_next;
    logic       wr_now, wr_reg, wr_event, accept, busy;
    logic [7:0] addr_reg;
    logic [7:0] din_op_reg;
    logic [4:0] field_reg, field_dec;
    logic [4:0] target_reg, target_dec;
    logic [4:0] slot_reg;
    logic [4:0] rev_reg;
    logic       off_ok, dec_valid;
    logic [4:0] up_vec;
    logic [2:0] upd_vec;

    assign wr_now   = ~bus.cs_n & ~bus.wr_n;
    assign wr_event = wr_now & ~wr_reg;
    assign busy     = (state_reg == ST_HOLD);
    assign accept   = wr_event & bus.addr & ~busy & dec_valid;

    // Decode the latched address into a one-hot field select and operator index
    always_comb begin
        field_dec = '0;
        case (addr_reg[7:5])
            3'd1: field_dec = 5'b00001;
            3'd2: field_dec = 5'b00010;
            3'd3: field_dec = 5'b00100;
            3'd4: field_dec = 5'b01000;
            3'd7: if (OPL2 != 0) field_dec = 5'b10000;
            default: field_dec = '0;
        endcase
        off_ok     = (addr_reg[4:3] != 2'd3) && (addr_reg[2:0] <= 3'd5);
        target_dec = 5'(addr_reg[4:3]) * 5'd6 + 5'(addr_reg[2:0]);
        dec_valid  = (|field_dec) & off_ok;
    end

    // Edge detector history for the CPU write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_reg <= 1'b0;
        else     wr_reg <= wr_now;
    end

    // Address port writes are always taken, even while a data write is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         addr_reg <= '0;
        else if (wr_event && !bus.addr)  addr_reg <= bus.din;
    end

    // Slot counter tracks the operator entering the ring on every ring tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          slot_reg <= '0;
        else if (bus.cen) slot_reg <= (slot_reg == 5'(LEN - 1)) ? 5'd0 : slot_reg + 5'd1;
    end

    // Revolution counter: loaded on accept, counts ring ticks while pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 rev_reg <= '0;
        else if (accept)         rev_reg <= 5'(LEN);
        else if (busy && bus.cen) rev_reg <= rev_reg - 5'd1;
    end

    // Pending write payload, captured only when a data write is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_op_reg <= '0;
            field_reg  <= '0;
            target_reg <= '0;
        end else if (accept) begin
            din_op_reg <= bus.din;
            field_reg  <= field_dec;
            target_reg <= target_dec;
        end
    end

    // Pending-write state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state: hold for a full revolution, release on the last ring tick
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_HOLD;
            ST_HOLD: if (bus.cen && rev_reg == 5'd1) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_up
            assign up_vec[gi] = busy & field_reg[gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_upd
            localparam int OFS = (gi == 0) ? 0 : (gi == 1) ? OFS_II : OFS_IV;
            localparam logic [5:0] OFS_MOD = 6'(OFS % LEN);
            logic [5:0] sum;
            logic [4:0] pos;
            // Physical slot of this field tap for the target operator, modulo LEN
            always_comb begin
                sum = {1'b0, target_reg} + OFS_MOD;
                pos = (sum >= 6'(LEN)) ? 5'(sum - 6'(LEN)) : sum[4:0];
            end
            assign upd_vec[gi] = busy & bus.cen & (slot_reg == pos);
        end
    endgenerate

    assign bus.busy         = busy;
    assign bus.slot         = slot_reg;
    assign bus.din_op       = din_op_reg;
    assign bus.up_mult      = up_vec[0];
    assign bus.up_ksl_tl    = up_vec[1];
    assign bus.up_ar_dr     = up_vec[2];
    assign bus.up_sl_rr     = up_vec[3];
    assign bus.up_wav       = up_vec[4];
    assign bus.update_op_I  = upd_vec[0];
    assign bus.update_op_II = upd_vec[1];
    assign bus.update_op_IV = upd_vec[2];

endmodule

// File: tb/tb_jtopl_reg_wr.sv
// Bench for jtopl_reg_wr: two instances (OPL2=1 and OPL2=0) on shared stimulus,
// a per-cycle reference model, a decode vector table and hand-written sequences.
module tb_jtopl_reg_wr;
    localparam int LEN = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtopl_reg_wr_if bus0();
    jtopl_reg_wr_if bus1();

    assign bus1.cen  = bus0.cen;
    assign bus1.addr = bus0.addr;
    assign bus1.din  = bus0.din;
    assign bus1.cs_n = bus0.cs_n;
    assign bus1.wr_n = bus0.wr_n;

    jtopl_reg_wr #(.LEN(LEN), .OFS_II(1), .OFS_IV(3), .OPL2(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    jtopl_reg_wr #(.LEN(LEN), .OFS_II(1), .OFS_IV(3), .OPL2(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (tick-count based) ----------------
    bit         m_opl2   [2] = '{1'b1, 1'b0};
    bit         m_prev_wr[2];
    logic [7:0] m_alatch [2];
    int         m_ticks  [2];
    bit         m_pend   [2];
    int         m_end    [2];
    int         m_field  [2];
    int         m_target [2];
    logic [7:0] m_data   [2];
    bit         cen_v = 1'b1;

    function automatic bit m_busy(input int m);
        return m_pend[m] && (m_ticks[m] < m_end[m]);
    endfunction

    function automatic bit decode(input logic [7:0] a, input bit opl2,
                                  output int field, output int target);
        int hi, off, grp, sub;
        hi  = int'(a) / 32;
        off = int'(a) % 32;
        grp = off / 8;
        sub = off % 8;
        case (hi)
            1: field = 0;
            2: field = 1;
            3: field = 2;
            4: field = 3;
            7: field = opl2 ? 4 : -1;
            default: field = -1;
        endcase
        target = grp * 6 + sub;
        return (field >= 0) && (grp <= 2) && (sub <= 5);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_prev_wr[m] = 0; m_alatch[m] = 8'h00; m_ticks[m] = 0; m_pend[m] = 0;
            m_end[m] = 0; m_field[m] = 0; m_target[m] = 0; m_data[m] = 8'h00;
        end
    endtask

    task automatic model_step(input bit cen, input bit cs_n, input bit wr_n,
                              input bit a, input logic [7:0] d);
        for (int m = 0; m < 2; m++) begin
            bit wr_now, ev, busy_b, acc;
            int f, t;
            wr_now = !cs_n && !wr_n;
            ev     = wr_now && !m_prev_wr[m];
            busy_b = m_busy(m);
            acc    = 0;
            f = 0; t = 0;
            if (ev) begin
                if (!a) m_alatch[m] = d;
                else if (!busy_b && decode(m_alatch[m], m_opl2[m], f, t)) acc = 1;
            end
            if (cen) m_ticks[m]++;
            if (acc) begin
                m_pend[m] = 1; m_end[m] = m_ticks[m] + LEN;
                m_field[m] = f; m_target[m] = t; m_data[m] = d;
            end
            m_prev_wr[m] = wr_now;
        end
    endtask

    task automatic check_one(input int m, input bit cen, input logic busy,
                             input logic [4:0] slot, input logic [7:0] dop,
                             input logic [4:0] up, input logic [2:0] upd);
        bit eb;
        int es;
        logic [4:0] eup;
        logic [2:0] eupd;
        int ofs [3];
        ofs = '{0, 1, 3};
        eb  = m_busy(m);
        es  = m_ticks[m] % LEN;
        eup = eb ? 5'(1 << m_field[m]) : 5'd0;
        for (int k = 0; k < 3; k++)
            eupd[k] = eb && cen && (es == (m_target[m] + ofs[k]) % LEN);
        chk($sformatf("dut%0d busy", m),   32'(busy), 32'(eb));
        chk($sformatf("dut%0d slot", m),   32'(slot), 32'(es));
        chk($sformatf("dut%0d din_op", m), 32'(dop),  32'(m_data[m]));
        chk($sformatf("dut%0d up", m),     32'(up),   32'(eup));
        chk($sformatf("dut%0d update", m), 32'(upd),  32'(eupd));
    endtask

    // ---------------- drivers ----------------
    logic       last_busy;
    logic [4:0] last_slot;
    logic [4:0] last_up;
    logic [2:0] last_upd;
    logic [7:0] last_dop;

    task automatic cycle(input bit cs_n, input bit wr_n, input bit a, input logic [7:0] d);
        bus0.cen = cen_v; bus0.cs_n = cs_n; bus0.wr_n = wr_n; bus0.addr = a; bus0.din = d;
        #1;
        last_busy = bus0.busy; last_slot = bus0.slot; last_dop = bus0.din_op;
        last_up  = {bus0.up_wav, bus0.up_sl_rr, bus0.up_ar_dr, bus0.up_ksl_tl, bus0.up_mult};
        last_upd = {bus0.update_op_IV, bus0.update_op_II, bus0.update_op_I};
        check_one(0, cen_v, bus0.busy, bus0.slot, bus0.din_op, last_up, last_upd);
        check_one(1, cen_v, bus1.busy, bus1.slot, bus1.din_op,
                  {bus1.up_wav, bus1.up_sl_rr, bus1.up_ar_dr, bus1.up_ksl_tl, bus1.up_mult},
                  {bus1.update_op_IV, bus1.update_op_II, bus1.update_op_I});
        @(posedge clk);
        model_step(cen_v, cs_n, wr_n, a, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus0.cs_n = 1'b1; bus0.wr_n = 1'b1; bus0.addr = 1'b0; bus0.din = 8'h00; bus0.cen = cen_v;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst busy",   32'(bus0.busy), 32'd0);
        chk("rst slot",   32'(bus0.slot), 32'd0);
        chk("rst din_op", 32'(bus0.din_op), 32'd0);
        chk("rst up", 32'({bus0.up_wav, bus0.up_sl_rr, bus0.up_ar_dr, bus0.up_ksl_tl, bus0.up_mult}), 32'd0);
        chk("rst update", 32'({bus0.update_op_IV, bus0.update_op_II, bus0.update_op_I}), 32'd0);
        chk("rst busy1",  32'(bus1.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_addr(input logic [7:0] a);
        cycle(1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    int         w_bcnt;
    int         w_fc [3];
    int         w_fs [3];
    logic [4:0] w_up0;
    logic [7:0] w_dop0;

    // Runs idle cycles (first one releases the write strobe) until busy drops
    task automatic watch();
        w_bcnt = 0;
        for (int k = 0; k < 3; k++) begin w_fc[k] = 0; w_fs[k] = -1; end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
            if (i == 0) begin w_up0 = last_up; w_dop0 = last_dop; end
            if (last_busy) w_bcnt++;
            for (int k = 0; k < 3; k++)
                if (last_upd[k]) begin w_fc[k]++; w_fs[k] = int'(last_slot); end
            if (!last_busy) break;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         valid;
        int         field;
        int         target;
    } vec_t;

    vec_t vecs [11];
    int   s_frozen;
    logic cs_r, wr_r;
    int   r;

    initial begin
        bus0.cen = 1'b1; bus0.cs_n = 1'b1; bus0.wr_n = 1'b1; bus0.addr = 1'b0; bus0.din = 8'h00;
        vecs = '{
            '{8'h23, 8'hA5, 1'b1, 0, 3},
            '{8'h55, 8'h3F, 1'b1, 1, 17},
            '{8'h26, 8'hFF, 1'b0, 0, 0},
            '{8'h38, 8'hFF, 1'b0, 0, 0},
            '{8'hE0, 8'h5A, 1'b1, 4, 0},
            '{8'h65, 8'h12, 1'b1, 2, 5},
            '{8'h92, 8'h34, 1'b1, 3, 14},
            '{8'h06, 8'h77, 1'b0, 0, 0},
            '{8'hB0, 8'h77, 1'b0, 0, 0},
            '{8'h7D, 8'h77, 1'b0, 0, 0},
            '{8'hF5, 8'hC3, 1'b1, 4, 17}
        };
        @(negedge clk);

        // 1: reset then slot sequence across 40 ring ticks
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
            chk($sformatf("slot_seq[%0d]", i), 32'(last_slot), 32'(i % LEN));
        end

        // 2-4: decode table
        for (int v = 0; v < 11; v++) begin
            write_addr(vecs[v].a);
            cycle(1'b0, 1'b0, 1'b1, vecs[v].d);
            watch();
            chk($sformatf("v%0d busy_ticks", v), 32'(w_bcnt), vecs[v].valid ? 32'd18 : 32'd0);
            chk($sformatf("v%0d up", v), 32'(w_up0), vecs[v].valid ? 32'(1 << vecs[v].field) : 32'd0);
            for (int k = 0; k < 3; k++)
                chk($sformatf("v%0d fires%0d", v, k), 32'(w_fc[k]), 32'(vecs[v].valid));
            if (vecs[v].valid) begin
                chk($sformatf("v%0d din_op", v), 32'(w_dop0), 32'(vecs[v].d));
                chk($sformatf("v%0d slot_I", v),  32'(w_fs[0]), 32'(vecs[v].target));
                chk($sformatf("v%0d slot_II", v), 32'(w_fs[1]), 32'((vecs[v].target + 1) % LEN));
                chk($sformatf("v%0d slot_IV", v), 32'(w_fs[2]), 32'((vecs[v].target + 3) % LEN));
            end
            if (vecs[v].a == 8'hE0) chk("opl2_off busy", 32'(bus1.busy), 32'd0);
        end

        // 5: write while busy is dropped; write coinciding with busy clear is dropped
        do_reset();
        write_addr(8'h23);
        cycle(1'b0, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        write_addr(8'h41);
        cycle(1'b0, 1'b0, 1'b1, 8'h11);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("held up_mult", 32'(last_up), 32'd1);
        chk("held din_op",  32'(last_dop), 32'hA5);
        chk("held busy",    32'(last_busy), 32'd1);
        for (int i = 0; i < 40 && m_busy(0) && (m_end[0] - m_ticks[0] > 1); i++)
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h22);
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("drop_on_clear busy", 32'(last_busy), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'h22);
        watch();
        chk("after up_ksl_tl", 32'(w_up0), 32'd2);
        chk("after din_op", 32'(w_dop0), 32'h22);
        chk("after slot_I", 32'(w_fs[0]), 32'd1);

        // 6: cen low freezes; async reset mid-revolution
        do_reset();
        write_addr(8'h23);
        cycle(1'b0, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cen_v = 1'b0;
        s_frozen = int'(bus0.slot);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
            chk("frozen slot", 32'(last_slot), 32'(s_frozen));
            chk("frozen busy", 32'(last_busy), 32'd1);
            chk("frozen update", 32'(last_upd), 32'd0);
        end
        cen_v = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cen_v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            cs_r = !(r <= 3 && r != 3);
            wr_r = !(r <= 3);
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(cs_r, wr_r, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? 8'($urandom_range(8'h20, 8'hF5)) : 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
